// File: rtl/relu_tile_sched_pkg.sv
// Shared types for the ReLU epilogue sequencer.
// Contents:
//   relu_state_t  - sequencer states
//   relu_entry_t  - skid FIFO entry {addr, data}; data is the raw X word so the
//                   sign bit is still available when the write is accepted
//   relu_fp32     - sign-bit clamp (no NaN special-casing)
package relu_pkg;

  // Storage widths of a FIFO entry; the top-level ADDR_W/Data_W default to these.
  localparam int RELU_ADDR_W = 16;
  localparam int RELU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } relu_state_t;

  typedef struct packed {
    logic [RELU_ADDR_W-1:0] addr;
    logic [RELU_DATA_W-1:0] data;
  } relu_entry_t;

  // Any word with the sign bit set becomes +0.0, including -0.0 and negative NaNs.
  function automatic logic [RELU_DATA_W-1:0] relu_fp32(input logic [RELU_DATA_W-1:0] x);
    return x[RELU_DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_tile_sched_if.sv
// X-read / Y-write bus between the ReLU sequencer and the tile buffers.
// Signals:
//   x_re, x_addr   - X read strobe/address (sequencer -> X buffer)
//   x_rdata        - X read data, valid one cycle after x_re
//   y_we, y_addr,
//   y_wdata        - Y write valid/address/data (sequencer -> Y buffer)
//   y_wready       - Y buffer accepts the write when y_we & y_wready
// Modports: master = sequencer side, slave = buffer side.
interface relu_tile_sched_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              x_re;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_rdata;
  logic              y_we;
  logic [ADDR_W-1:0] y_addr;
  logic [DATA_W-1:0] y_wdata;
  logic              y_wready;

  modport master (
    output x_re, x_addr, y_we, y_addr, y_wdata,
    input  x_rdata, y_wready
  );

  modport slave (
    input  x_re, x_addr, y_we, y_addr, y_wdata,
    output x_rdata, y_wready
  );

endinterface

// File: rtl/relu_tile_sched_skid_fifo.sv
// Two-entry skid FIFO holding returned X words until the Y side accepts them.
// Slot 0 is always the head, so the head outputs come straight from a register
// and stay put while the consumer stalls.
// Ports:
//   clk, rst  - clock, async active-high reset
//   push_i    - write entry_i
//   pop_i     - drop the head (only honoured when non-empty)
//   flush_i   - empty the FIFO; wins over push/pop
//   entry_i   - entry to push
//   head_o    - current head entry
//   count_o   - number of valid entries (0..2)
module relu_skid_fifo
  import relu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  relu_entry_t entry_i,
  output relu_entry_t head_o,
  output logic [1:0]  count_o
);

  relu_entry_t slot0_q, slot0_d;
  relu_entry_t slot1_q, slot1_d;
  logic [1:0]  count_q, count_d;

  // Next-state for the two slots; a push into a full FIFO without a pop is
  // dropped rather than overwriting, though the sequencer never requests one.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i && (count_q != 2'd0)})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = entry_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            slot1_d = entry_i;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = entry_i;
          end else begin
            slot0_d = entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot0_q;
  assign count_o = count_q;

endmodule

// File: rtl/relu_tile_sched.sv
// ReLU epilogue sequencer: walks an NRows x NCols tile in row-major order,
// reads X, clamps negatives to zero and writes Y under ready/valid, with a
// 2-entry skid FIFO absorbing Y back-pressure against the 1-cycle X latency.
// Ports:
//   clk, rst   - clock, async active-high reset
//   start_i    - begin a tile pass (only looked at in IDLE)
//   abort_i    - cancel a pass in RUN/DRAIN
//   busy_o     - pass in progress (RUN or DRAIN)
//   done_o     - one-cycle pulse after the last Y write is accepted
//   neg_cnt_o  - elements clamped in the current/last pass
//   bus        - X read / Y write bus (master side)
module relu_tile_sched
  import relu_pkg::*;
#(
  parameter  int NRows  = 8,
  parameter  int NCols  = 8,
  parameter  int ADDR_W = 16,
  parameter  int Data_W = 32,
  localparam int N      = NRows * NCols,
  localparam int CNT_W  = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] neg_cnt_o,
  relu_tile_sched_if.master bus
);

  relu_state_t       state_q, state_d;
  logic [CNT_W-1:0]  issueIdx_q, issueIdx_d;
  logic [CNT_W-1:0]  negCnt_q, negCnt_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflightAddr_q;

  logic              active, startNow, abortNow, issue;
  logic              fifoPush, fifoPop, fifoFlush;
  logic [1:0]        fifoCount;
  logic [2:0]        occupancy;
  relu_entry_t       pushEntry, headEntry;

  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign startNow = (state_q == IDLE) && start_i && !abort_i;
  assign abortNow = active && abort_i;
  assign fifoPop  = bus.y_we && bus.y_wready;

  // An element leaving this cycle frees its slot, so a read may be issued as
  // long as buffered + outstanding stays within the two FIFO entries.
  assign occupancy = {1'b0, fifoCount} + {2'b00, inflight_q};
  assign issue     = (state_q == RUN) && (occupancy < (3'd2 + {2'b00, fifoPop}));

  // Returned data is only kept while a pass is live; anything arriving after
  // an abort is dropped.
  assign fifoPush  = inflight_q && active && !abort_i;
  assign fifoFlush = abortNow || startNow;

  always_comb begin
    pushEntry      = '0;
    pushEntry.addr = RELU_ADDR_W'(inflightAddr_q);
    pushEntry.data = RELU_DATA_W'(bus.x_rdata);
  end

  relu_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (fifoFlush),
    .entry_i (pushEntry),
    .head_o  (headEntry),
    .count_o (fifoCount)
  );

  // Next-state, issue index and clamp counter. DRAIN finishes once nothing is
  // outstanding and the FIFO empties this cycle, so done follows the last
  // accepted write directly.
  always_comb begin
    state_d    = state_q;
    issueIdx_d = issueIdx_q;
    negCnt_d   = negCnt_q;
    if (fifoPop && headEntry.data[RELU_DATA_W-1]) begin
      negCnt_d = negCnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (startNow) begin
          state_d    = RUN;
          issueIdx_d = '0;
          negCnt_d   = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (issue) begin
          issueIdx_d = issueIdx_q + 1'b1;
          if (issueIdx_q == CNT_W'(N - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (!inflight_q && (fifoCount == {1'b0, fifoPop})) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and the single outstanding-read tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      issueIdx_q     <= '0;
      negCnt_q       <= '0;
      inflight_q     <= 1'b0;
      inflightAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      issueIdx_q <= issueIdx_d;
      negCnt_q   <= negCnt_d;
      inflight_q <= issue && !abortNow;
      if (issue) begin
        inflightAddr_q <= ADDR_W'(issueIdx_q);
      end
    end
  end

  assign bus.x_re    = issue;
  assign bus.x_addr  = issue ? ADDR_W'(issueIdx_q) : '0;
  assign bus.y_we    = (fifoCount != 2'd0);
  assign bus.y_addr  = bus.y_we ? ADDR_W'(headEntry.addr) : '0;
  assign bus.y_wdata = bus.y_we ? Data_W'(relu_fp32(headEntry.data)) : '0;

  assign busy_o    = active;
  assign done_o    = (state_q == DONE);
  assign neg_cnt_o = negCnt_q;

endmodule

// File: tb/tb_relu_tile_sched.sv
// Self-checking bench for relu_tile_sched (8x8 tile). The Y write stream is
// collected by a monitor and compared against the tile contents passed through
// a sign-rule ReLU; cycle timing, abort, reset and start-filtering are checked
// with directed steps.
module tb_relu_tile_sched;

  localparam int NELEM = 64;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [6:0] negCnt;

  relu_tile_sched_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  relu_tile_sched #(
    .NRows  (8),
    .NCols  (8),
    .ADDR_W (16),
    .Data_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .abort_i   (abort),
    .busy_o    (busy),
    .done_o    (done),
    .neg_cnt_o (negCnt),
    .bus       (bus)
  );

  logic [31:0] xMem [NELEM];
  logic [15:0] yAddrQ [$];
  logic [31:0] yDataQ [$];

  int vectorCount;
  int miscompareCount;
  int doneCycle, doneCount, busyCycles, firstReCycle, firstWeCycle;
  int stallViol;
  int addrViol;
  bit monEnable;
  bit reAt   [0:599];
  bit weAt   [0:599];
  bit busyAt [0:599];

  logic        prevStall;
  logic [15:0] prevAddr;
  logic [31:0] prevData;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // X buffer: data for the address read in the previous cycle, junk otherwise.
  always @(posedge clk) begin
    if (bus.x_re) begin
      if (bus.x_addr >= 16'(NELEM)) addrViol++;
      bus.x_rdata <= xMem[bus.x_addr[5:0]];
    end else begin
      bus.x_rdata <= $urandom;
    end
  end

  // Y buffer: record accepted writes and flag any head change during a stall.
  always @(posedge clk) begin
    if (!rst) begin
      if (monEnable) begin
        if (prevStall && !(bus.y_we && bus.y_addr == prevAddr && bus.y_wdata == prevData))
          stallViol++;
        prevStall = bus.y_we && !bus.y_wready;
        prevAddr  = bus.y_addr;
        prevData  = bus.y_wdata;
      end else begin
        prevStall = 1'b0;
      end
      if (bus.y_we && bus.y_wready) begin
        yAddrQ.push_back(bus.y_addr);
        yDataQ.push_back(bus.y_wdata);
      end
    end else begin
      prevStall = 1'b0;
    end
  end

  // Reference ReLU: negative-signed words become zero.
  function automatic logic [31:0] refRelu(input logic [31:0] x);
    if ($signed(x) < 0) return 32'd0;
    return x;
  endfunction

  function automatic int refNegCount();
    int n = 0;
    for (int i = 0; i < NELEM; i++)
      if ($signed(xMem[i]) < 0) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      miscompareCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus, driven on the falling edge.
  task automatic applyStimulus(input logic startVal, input logic abortVal, input int readyPct);
    @(negedge clk);
    start        = startVal;
    abort        = abortVal;
    bus.y_wready = ($urandom_range(99) < readyPct);
  endtask

  // Pulses start at cycle 0 (the following edge is E0), then runs up to
  // nCycles recording per-cycle observations; cycle c is c cycles after E0.
  task automatic runPass(input int readyPct, input int nCycles, input bit stopOnDone,
                         input int extraStart, input int abortAt);
    doneCycle    = -1;
    doneCount    = 0;
    busyCycles   = 0;
    firstReCycle = -1;
    firstWeCycle = -1;
    yAddrQ.delete();
    yDataQ.delete();
    for (int c = 0; c <= nCycles; c++) begin
      applyStimulus((c == 0) || (c == extraStart), c == abortAt, readyPct);
      #1;
      reAt[c]   = bus.x_re;
      weAt[c]   = bus.y_we;
      busyAt[c] = busy;
      if (c > 0) begin
        if (busy) busyCycles++;
        if (bus.x_re && firstReCycle < 0) firstReCycle = c;
        if (bus.y_we && firstWeCycle < 0) firstWeCycle = c;
        if (done) begin
          doneCount++;
          if (doneCycle < 0) doneCycle = c;
        end
      end
      if (stopOnDone && doneCycle >= 0) break;
    end
  endtask

  // Compare the captured Y stream with the model for the current tile.
  task automatic checkYSeq(input string tag);
    checkOutput({tag, ".writes"}, 64'(yAddrQ.size()), 64'(NELEM));
    for (int i = 0; i < NELEM; i++) begin
      if (i < yAddrQ.size()) begin
        checkOutput($sformatf("%s.addr[%0d]", tag, i), 64'(yAddrQ[i]), 64'(i));
        checkOutput($sformatf("%s.data[%0d]", tag, i), 64'(yDataQ[i]), 64'(refRelu(xMem[i])));
      end
    end
    checkOutput({tag, ".negCnt"}, 64'(negCnt), 64'(refNegCount()));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    stallViol       = 0;
    addrViol        = 0;
    monEnable       = 1'b1;
    prevStall       = 1'b0;
    rst             = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    bus.y_wready    = 1'b0;
    for (int i = 0; i < NELEM; i++) xMem[i] = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset.busy",   64'(busy),        64'd0);
    checkOutput("reset.done",   64'(done),        64'd0);
    checkOutput("reset.x_re",   64'(bus.x_re),    64'd0);
    checkOutput("reset.y_we",   64'(bus.y_we),    64'd0);
    checkOutput("reset.negCnt", 64'(negCnt),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Alternating +1.0 / -2.0 at full throughput: exact cycle timing.
    $display("[TB] pass A: alternating data, y_wready high");
    for (int i = 0; i < NELEM; i++) xMem[i] = (i % 2 == 0) ? 32'h3F80_0000 : 32'hC000_0000;
    runPass(100, 100, 1'b1, -1, -1);
    checkOutput("A.firstRe",   64'(firstReCycle), 64'd1);
    checkOutput("A.firstWe",   64'(firstWeCycle), 64'd3);
    checkOutput("A.busyCyc",   64'(busyCycles),   64'(NELEM + 2));
    checkOutput("A.doneCycle", 64'(doneCycle),    64'(NELEM + 3));
    checkOutput("A.negCnt32",  64'(negCnt),       64'd32);
    checkYSeq("A");

    // start together with abort in IDLE: nothing happens, neg_cnt untouched.
    $display("[TB] start&abort in IDLE");
    runPass(100, 10, 1'b0, -1, 0);
    checkOutput("SA.busyCyc", 64'(busyCycles),           64'd0);
    checkOutput("SA.firstRe", 64'(firstReCycle),         -64'sd1);
    checkOutput("SA.done",    64'(doneCount),            64'd0);
    checkOutput("SA.writes",  64'(yAddrQ.size()),        64'd0);
    checkOutput("SA.negCnt",  64'(negCnt),               64'd32);

    // Signed-zero and NaN corner cases under 50% back-pressure.
    $display("[TB] pass B: -0.0 / negative NaN / positive NaN, y_wready 50%%");
    for (int i = 0; i < NELEM; i++) xMem[i] = $urandom & 32'h7FFF_FFFF;
    xMem[5] = 32'h8000_0000;
    xMem[6] = 32'hFFC0_0000;
    xMem[7] = 32'h7FC0_0000;
    runPass(50, 500, 1'b1, -1, -1);
    checkOutput("B.doneSeen", 64'(doneCycle > 0), 64'd1);
    checkYSeq("B");
    checkOutput("B.y5",     64'(yDataQ[5]), 64'h0);
    checkOutput("B.y6",     64'(yDataQ[6]), 64'h0);
    checkOutput("B.y7",     64'(yDataQ[7]), 64'h7FC0_0000);
    checkOutput("B.negCnt2", 64'(negCnt),   64'd2);
    checkOutput("B.stall",  64'(stallViol), 64'd0);

    // Fully random data under heavy back-pressure.
    $display("[TB] pass C: random data, y_wready 30%%");
    for (int i = 0; i < NELEM; i++) xMem[i] = $urandom;
    runPass(30, 580, 1'b1, -1, -1);
    checkOutput("C.doneSeen", 64'(doneCycle > 0), 64'd1);
    checkYSeq("C");
    checkOutput("C.stall", 64'(stallViol), 64'd0);

    // A second start while busy must be ignored: exactly one done.
    $display("[TB] start during busy");
    for (int i = 0; i < NELEM; i++) xMem[i] = $urandom;
    runPass(100, 90, 1'b0, 10, -1);
    checkOutput("SB.doneCount", 64'(doneCount), 64'd1);
    checkOutput("SB.doneCycle", 64'(doneCycle), 64'(NELEM + 3));
    checkYSeq("SB");

    // Abort at cycle 20 while Y is stalled.
    $display("[TB] abort while stalled");
    monEnable = 1'b0;
    runPass(0, 40, 1'b0, -1, 20);
    checkOutput("AB.weBefore", 64'(weAt[20]),     64'd1);
    checkOutput("AB.weAfter",  64'(weAt[21]),     64'd0);
    checkOutput("AB.reAfter",  64'(reAt[21]),     64'd0);
    checkOutput("AB.busy",     64'(busyAt[21]),   64'd0);
    checkOutput("AB.done",     64'(doneCount),    64'd0);
    checkOutput("AB.writes",   64'(yAddrQ.size()), 64'd0);
    checkOutput("AB.negCnt",   64'(negCnt),       64'd0);
    monEnable = 1'b1;

    // Full pass after the abort.
    $display("[TB] pass after abort");
    for (int i = 0; i < NELEM; i++) xMem[i] = $urandom;
    runPass(100, 100, 1'b1, -1, -1);
    checkOutput("PA.doneCycle", 64'(doneCycle), 64'(NELEM + 3));
    checkYSeq("PA");

    // Reset mid-pass: outputs clear before the next clock edge.
    $display("[TB] reset mid-pass");
    for (int i = 0; i < NELEM; i++) xMem[i] = 32'h8000_0000 | $urandom;
    monEnable = 1'b0;
    runPass(100, 30, 1'b1, -1, -1);
    checkOutput("RS.busyBefore", 64'(busyAt[30]), 64'd1);
    checkOutput("RS.negBefore",  64'(negCnt > 0), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("RS.busy",    64'(busy),        64'd0);
    checkOutput("RS.done",    64'(done),        64'd0);
    checkOutput("RS.x_re",    64'(bus.x_re),    64'd0);
    checkOutput("RS.x_addr",  64'(bus.x_addr),  64'd0);
    checkOutput("RS.y_we",    64'(bus.y_we),    64'd0);
    checkOutput("RS.y_addr",  64'(bus.y_addr),  64'd0);
    checkOutput("RS.y_wdata", 64'(bus.y_wdata), 64'd0);
    checkOutput("RS.negCnt",  64'(negCnt),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b0, 100);
      #1;
      checkOutput($sformatf("RS.idleBusy[%0d]", c), 64'(busy),     64'd0);
      checkOutput($sformatf("RS.idleRe[%0d]", c),   64'(bus.x_re), 64'd0);
    end
    monEnable = 1'b1;

    checkOutput("addrRange", 64'(addrViol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/relu_tile_sched.md
# relu_tile_sched

Sequencer for the FP32 ReLU epilogue stage of the EPU. On `start` it walks an NRows×NCols tile in row-major order, issues reads to the X buffer, applies the sign-bit ReLU, and writes results to the Y buffer under a ready/valid write handshake. A 2-entry skid buffer absorbs Y back-pressure against the fixed 1-cycle X read latency. Sits between the CPU/TPU result buffers and the ReLU datapath.

## Interface
- `NRows`, 8, tile rows
- `NCols`, 8, tile columns
- `ADDR_W`, 16, buffer address width; must satisfy NRows*NCols ≤ 2^ADDR_W
- `Data_W`, 32, element width (FP32, sign at bit Data_W-1)
- Derived: N = NRows*NCols; CNT_W = $clog2(N+1)
- `clk` in 1 — single clock, all logic posedge
- `rst` in 1 — asynchronous, active-high reset
- `start` in 1 — begin tile pass (sampled in IDLE only)
- `abort` in 1 — cancel pass in progress
- `busy` out 1 — pass in progress (RUN or DRAIN)
- `done` out 1 — 1-cycle pulse after last Y write accepted
- `x_re` out 1 — X read strobe
- `x_addr` out ADDR_W — X address, row*NCols+col
- `x_rdata` in Data_W — valid exactly one cycle after `x_re`, unconditionally
- `y_we` out 1 — Y write valid
- `y_addr` out ADDR_W — Y address (same index as source X)
- `y_wdata` out Data_W — ReLU result
- `y_wready` in 1 — Y accepts write when `y_we & y_wready`
- `neg_cnt` out CNT_W — count of elements clamped in the last/current pass

## Operation
- States: IDLE, RUN, DRAIN, DONE. `busy` = RUN|DRAIN; `done` = (state==DONE).
- IDLE: `start & !abort` → RUN; clear issue index, `neg_cnt`, buffer. `start` in any other state ignored.
- RUN: `x_re` asserted when `fifo_cnt + inflight − pop < 2` (pop = `y_we & y_wready`); index increments per issue. After issuing index N−1 → DRAIN.
- DRAIN: no issues; when inflight==0, fifo empty, → DONE.
- DONE: one cycle, → IDLE.
- Returned `x_rdata` pushed with its address into the 2-entry FIFO; head drives `y_we/y_addr/y_wdata`. `y_addr/y_wdata` held stable while `y_we & !y_wready`.
- ReLU: `y = x[Data_W-1] ? 0 : x`. −0.0 (0x80000000) → 0x00000000 and counted; negative NaN → 0 (sign rule only, no NaN handling).
- `neg_cnt` increments on each accepted write whose source sign bit was 1; holds after DONE until next accepted `start`.
- `abort` in RUN/DRAIN: `x_re`, `y_we` deassert next cycle; FIFO flushed; in-flight read data discarded; → IDLE, no `done`; `neg_cnt` frozen. `abort` with `start` in IDLE: stay IDLE.
- Addresses never exceed N−1; no wrap.

## Timing
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0; takes effect immediately mid-pass, no completion.
- `start` at edge E0 → first `x_re` (addr 0) in cycle 1; `x_rdata` cycle 2; `y_we` addr 0 cycle 3.
- With `y_wready` held high: one element per cycle; last `x_re` cycle N, last `y_we` cycle N+2, `done` cycle N+3; `busy` cycles 1..N+2.
- Back-pressure: at most 2 elements buffered + 0 outstanding, or 1 buffered + 1 outstanding; no data loss, no overwrite.
- `x_re`, `x_addr` combinational from state/counters/FIFO; `y_*` driven from FIFO registers.

## Structure
- Package `relu_pkg`: state enum typedef `relu_state_t`, FIFO entry struct `{addr, data}`, function `relu_fp32` (sign-bit clamp).
- Sub-module `relu_skid_fifo` (2-entry, push/pop/flush, count out). FSM, index counter, inflight flag and `neg_cnt` in top.

## Test plan
- N=64, `y_wready`=1, X = alternating +1.0 (0x3F800000)/−2.0 (0xC0000000) → Y alternates 0x3F800000/0, `neg_cnt`=32, `done` exactly cycle 67 after start edge.
- `y_wready` random 50% → every Y address 0..63 written once in order, data matches ReLU model, no `y_wdata` change while stalled.
- X[5]=0x80000000, X[6]=0xFFC00000, X[7]=0x7FC00000 → Y[5]=0, Y[6]=0, Y[7]=0x7FC00000, `neg_cnt`=2.
- `abort` at cycle 20 with `y_wready` low → `y_we`/`x_re` low next cycle, no `done`, `busy` low; following `start` completes full pass correctly.
- `rst` pulsed mid-pass → all outputs 0 asynchronously; `start` during busy ignored (single `done`); `start&abort` in IDLE → no activity.
